// File: rtl/reversi_pkg.sv
// ============================================================================
// Module      : reversi_pkg
// Description : Colour codes, winner codes and scorer states shared by the
//               board drawing, move and scoring blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reversi_pkg;

  localparam logic [2:0] COLOUR_BLACK = 3'b000;
  localparam logic [2:0] COLOUR_WHITE = 3'b111;
  localparam logic [2:0] COLOUR_EMPTY = 3'b010;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_BLACK = 2'b01;
  localparam logic [1:0] WIN_WHITE = 2'b10;
  localparam logic [1:0] WIN_TIE   = 2'b11;

  typedef enum logic [1:0] {
    SC_IDLE  = 2'd0,
    SC_READ  = 2'd1,
    SC_DRAIN = 2'd2,
    SC_DONE  = 2'd3
  } scorer_state_t;

endpackage

`default_nettype wire

// File: rtl/board_addr_gen.sv
// ============================================================================
// Module      : board_addr_gen
// Description : Row-major x/y raster counter for sweeping the board store.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module board_addr_gen #(
  parameter int BOARD_DIM = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       step,
  output logic [2:0] x,
  output logic [2:0] y,
  output logic       last
);

  localparam logic [2:0] MAX_COORD = 3'(BOARD_DIM - 1);

  // Stepping past the final cell wraps back to (0,0).
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      x <= 3'd0;
      y <= 3'd0;
    end else if (step) begin
      if (x == MAX_COORD) begin
        x <= 3'd0;
        y <= (y == MAX_COORD) ? 3'd0 : y + 3'd1;
      end else begin
        x <= x + 3'd1;
      end
    end
  end

  assign last = (x == MAX_COORD) && (y == MAX_COORD);

endmodule

`default_nettype wire

// File: rtl/board_scorer.sv
// ============================================================================
// Module      : board_scorer
// Description : Scans the 8x8 board store and tallies black/white/empty cells.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module board_scorer
  import reversi_pkg::*;
#(
  parameter int BOARD_DIM = 8,
  parameter int CNT_W     = 7
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             scoreEn,
  output logic [2:0]       readX,
  output logic [2:0]       readY,
  input  logic [2:0]       readColour,
  output logic [CNT_W-1:0] blackCount,
  output logic [CNT_W-1:0] whiteCount,
  output logic [CNT_W-1:0] emptyCount,
  output logic [1:0]       winner,
  output logic             scoreBusy,
  output logic             scoreDone
);

  scorer_state_t    state;
  logic             addr_last;
  logic             count_en;
  logic             is_black;
  logic             is_white;
  logic             is_empty;
  logic [CNT_W-1:0] black_next;
  logic [CNT_W-1:0] white_next;
  logic [CNT_W-1:0] empty_next;
  logic [1:0]       winner_next;

  board_addr_gen #(
    .BOARD_DIM (BOARD_DIM)
  ) u_addr_gen (
    .clk    (clk),
    .resetn (resetn),
    .clear  (state == SC_IDLE),
    .step   (state == SC_READ),
    .x      (readX),
    .y      (readY),
    .last   (addr_last)
  );

  // The read port has one cycle of latency: the colour seen while address n
  // is presented belongs to address n-1, so nothing is counted at (0,0).
  assign count_en = ((state == SC_READ) && ({readY, readX} != 6'd0)) ||
                    (state == SC_DRAIN);

  always_comb begin
    is_black    = (readColour == COLOUR_BLACK);
    is_white    = (readColour == COLOUR_WHITE);
    is_empty    = (readColour == COLOUR_EMPTY) || (!is_black && !is_white);
    black_next  = blackCount + CNT_W'(count_en && is_black);
    white_next  = whiteCount + CNT_W'(count_en && is_white);
    empty_next  = emptyCount + CNT_W'(count_en && is_empty);
    winner_next = WIN_TIE;
    if (black_next > white_next) begin
      winner_next = WIN_BLACK;
    end else if (white_next > black_next) begin
      winner_next = WIN_WHITE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= SC_IDLE;
      blackCount <= '0;
      whiteCount <= '0;
      emptyCount <= '0;
      winner     <= WIN_NONE;
      scoreBusy  <= 1'b0;
      scoreDone  <= 1'b0;
    end else begin
      case (state)
        SC_IDLE: begin
          scoreDone <= 1'b0;
          if (scoreEn) begin
            blackCount <= '0;
            whiteCount <= '0;
            emptyCount <= '0;
            winner     <= WIN_NONE;
            scoreBusy  <= 1'b1;
            state      <= SC_READ;
          end
        end
        SC_READ: begin
          blackCount <= black_next;
          whiteCount <= white_next;
          emptyCount <= empty_next;
          if (addr_last) begin
            state <= SC_DRAIN;
          end
        end
        SC_DRAIN: begin
          // Winner uses the post-increment counts so it is valid with done.
          blackCount <= black_next;
          whiteCount <= white_next;
          emptyCount <= empty_next;
          winner     <= winner_next;
          scoreDone  <= 1'b1;
          state      <= SC_DONE;
        end
        SC_DONE: begin
          scoreDone <= 1'b0;
          scoreBusy <= 1'b0;
          state     <= SC_IDLE;
        end
        default: begin
          state <= SC_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_board_scorer.sv
// ============================================================================
// Module      : tb_board_scorer
// Description : Self-checking bench for board_scorer with a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_board_scorer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       scoreEn;
  logic [2:0] readX;
  logic [2:0] readY;
  logic [2:0] readColour;
  logic [6:0] blackCount;
  logic [6:0] whiteCount;
  logic [6:0] emptyCount;
  logic [1:0] winner;
  logic       scoreBusy;
  logic       scoreDone;

  always #5 clk = ~clk;

  board_scorer #(
    .BOARD_DIM (8),
    .CNT_W     (7)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .scoreEn    (scoreEn),
    .readX      (readX),
    .readY      (readY),
    .readColour (readColour),
    .blackCount (blackCount),
    .whiteCount (whiteCount),
    .emptyCount (emptyCount),
    .winner     (winner),
    .scoreBusy  (scoreBusy),
    .scoreDone  (scoreDone)
  );

  // Board store model with a registered read port.
  logic [2:0] board [64];
  always @(posedge clk) readColour <= board[{readY, readX}];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         black;
    int         white;
    int         empty;
    logic [1:0] win;
    int         done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input int done_cyc);
    exp_t e;
    e.black = 0;
    e.white = 0;
    e.empty = 0;
    for (int i = 0; i < 64; i++) begin
      case (board[i])
        3'b000:  e.black++;
        3'b111:  e.white++;
        default: e.empty++;
      endcase
    end
    e.win      = (e.black > e.white) ? 2'b01 : (e.white > e.black) ? 2'b10 : 2'b11;
    e.done_cyc = done_cyc;
    return e;
  endfunction

  task automatic fill_random();
    logic [2:0] codes [4];
    codes[0] = 3'b000; codes[1] = 3'b111; codes[2] = 3'b010; codes[3] = 3'b101;
    for (int i = 0; i < 64; i++) board[i] = codes[$urandom_range(0, 3)];
  endtask

  task automatic start_scan(input bit push, output int s);
    @(negedge clk);
    scoreEn = 1'b1;
    s = cyc + 1;
    if (push) begin
      last_exp = model(s + 65);
      sb.push_back(last_exp);
    end
    @(negedge clk);
    scoreEn = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check_val("done_wait", sb.size(), 0);
    @(negedge clk);
  endtask

  // Output side of the scoreboard: every done pulse must match a queued scan.
  always @(negedge clk) begin
    exp_t e;
    if (resetn === 1'b1 && scoreDone === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("unexpected_done", scoreDone, 1'b0);
      end else begin
        e = sb.pop_front();
        check_val("done_cycle", cyc, e.done_cyc);
        check_val("black", blackCount, e.black);
        check_val("white", whiteCount, e.white);
        check_val("empty", emptyCount, e.empty);
        check_val("winner", winner, e.win);
        check_val("sum64", blackCount + whiteCount + emptyCount, 64);
        check_val("busy_at_done", scoreBusy, 1'b1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   s;
    int   err;
    exp_t e;
    exp_t held;

    for (int i = 0; i < 64; i++) board[i] = 3'b010;
    resetn  = 1'b0;
    scoreEn = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_black", blackCount, 0);
    check_val("rst_white", whiteCount, 0);
    check_val("rst_empty", emptyCount, 0);
    check_val("rst_winner", winner, 0);
    check_val("rst_busy", scoreBusy, 0);
    check_val("rst_done", scoreDone, 0);
    check_val("rst_addr", {readY, readX}, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Opening position: tie 2:2.
    for (int i = 0; i < 64; i++) board[i] = 3'b010;
    board[27] = 3'b111; board[36] = 3'b111;
    board[28] = 3'b000; board[35] = 3'b000;
    start_scan(1'b1, s);
    wait_done();

    // All black except (7,7) white: last cell must be counted.
    for (int i = 0; i < 64; i++) board[i] = 3'b000;
    board[63] = 3'b111;
    start_scan(1'b1, s);
    wait_done();

    // 40 white, 20 black, 4 odd codes counted as empty.
    for (int i = 0; i < 64; i++) board[i] = (i < 40) ? 3'b111 : (i < 60) ? 3'b000 : 3'b101;
    start_scan(1'b1, s);
    wait_done();

    // scoreEn held high: address trace and automatic restart.
    fill_random();
    @(negedge clk);
    scoreEn = 1'b1;
    s = cyc + 1;
    e = model(s + 65);
    sb.push_back(e);
    e.done_cyc = s + 67 + 65;
    sb.push_back(e);
    err = 0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if ({readY, readX} != 6'(n) || scoreBusy !== 1'b1) err++;
    end
    check_val("addr_trace", err, 0);
    repeat (3) @(negedge clk);
    check_val("gap_busy", scoreBusy, 0);
    check_val("gap_addr", {readY, readX}, 0);
    @(negedge clk);
    check_val("restart_busy", scoreBusy, 1);
    check_val("restart_addr", {readY, readX}, 0);
    scoreEn = 1'b0;
    wait_done();

    // scoreEn pulse while busy is ignored.
    fill_random();
    start_scan(1'b1, s);
    repeat (9) @(negedge clk);
    scoreEn = 1'b1;
    @(negedge clk);
    scoreEn = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);
    check_val("no_spurious_start", scoreBusy, 0);

    // Reset in the middle of a scan aborts it without a done pulse.
    fill_random();
    start_scan(1'b0, s);
    while (cyc < s + 29) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check_val("abort_black", blackCount, 0);
    check_val("abort_white", whiteCount, 0);
    check_val("abort_empty", emptyCount, 0);
    check_val("abort_winner", winner, 0);
    check_val("abort_busy", scoreBusy, 0);
    check_val("abort_addr", {readY, readX}, 0);
    resetn = 1'b1;
    repeat (80) @(negedge clk);

    // Back-to-back scans: results hold, then clear at acceptance.
    fill_random();
    start_scan(1'b1, s);
    wait_done();
    held = last_exp;
    repeat (3) @(negedge clk);
    check_val("hold_black", blackCount, held.black);
    check_val("hold_white", whiteCount, held.white);
    check_val("hold_empty", emptyCount, held.empty);
    check_val("hold_winner", winner, held.win);
    fill_random();
    start_scan(1'b1, s);
    check_val("clr_black", blackCount, 0);
    check_val("clr_white", whiteCount, 0);
    check_val("clr_empty", emptyCount, 0);
    check_val("clr_winner", winner, 0);
    wait_done();

    check_val("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
